// File: rtl/tl_qos_arbiter_pkg.sv
// Shared TileLink-UL definitions for the QoS arbiter: opcodes, FSM states and beat math.
package tl_qos_arbiter_pkg;

    typedef enum logic [2:0] {
        PUT_FULL_DATA    = 3'd0,
        PUT_PARTIAL_DATA = 3'd1,
        GET              = 3'd4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } tl_d_op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int BEAT_CNT_W = 8;

    // Only Put messages carry data beats; everything else is a single-beat request.
    function automatic logic [BEAT_CNT_W-1:0] beat_count(input logic [2:0] opcode,
                                                         input logic [2:0] size,
                                                         input int bytes_per_beat);
        int beats;
        if (opcode != PUT_FULL_DATA && opcode != PUT_PARTIAL_DATA) begin
            return BEAT_CNT_W'(1);
        end
        beats = (1 << size) / bytes_per_beat;
        if (beats < 1) begin
            beats = 1;
        end
        return BEAT_CNT_W'(beats);
    endfunction

endpackage

// File: rtl/tl_qos_arbiter_if.sv
// Bundle of N packed TileLink-UL links (A and D channels); N=2 for requesters, N=1 for memory.
interface tl_qos_arbiter_if #(
    parameter int N  = 2,
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int SW = 1
);
    logic [N-1:0][2:0]      a_opcode;
    logic [N-1:0][2:0]      a_param;
    logic [N-1:0][2:0]      a_size;
    logic [N-1:0][SW-1:0]   a_source;
    logic [N-1:0][AW-1:0]   a_address;
    logic [N-1:0][DW/8-1:0] a_mask;
    logic [N-1:0][DW-1:0]   a_data;
    logic [N-1:0]           a_corrupt;
    logic [N-1:0]           a_valid;
    logic [N-1:0]           a_ready;

    logic [N-1:0][2:0]      d_opcode;
    logic [N-1:0][1:0]      d_param;
    logic [N-1:0][2:0]      d_size;
    logic [N-1:0][SW-1:0]   d_source;
    logic [N-1:0]           d_denied;
    logic [N-1:0]           d_corrupt;
    logic [N-1:0][DW-1:0]   d_data;
    logic [N-1:0]           d_valid;
    logic [N-1:0]           d_ready;

    modport master (
        output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
        input  a_ready,
        input  d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data, d_valid,
        output d_ready
    );

    modport slave (
        input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
        output a_ready,
        output d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data, d_valid,
        input  d_ready
    );

endinterface

// File: rtl/tl_beat_counter.sv
// Remaining-beat counter for a locked multi-beat A message; 'last' flags the final beat.
module tl_beat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);
    logic [W-1:0] beats_left;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats_left <= '0;
        end else if (load) begin
            beats_left <= load_val;
        end else if (dec && beats_left != '0) begin
            beats_left <= beats_left - 1'b1;
        end
    end

    assign last = (beats_left == W'(1));

endmodule

// File: rtl/tl_qos_arbiter.sv
// Two-requester TileLink-UL arbiter with fixed priority, starvation override and burst locking.
module tl_qos_arbiter
    import tl_qos_arbiter_pkg::*;
#(
    parameter int TL_DW        = 32,
    parameter int TL_AW        = 32,
    parameter int TL_SW        = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    tl_qos_arbiter_if.slave   req,
    tl_qos_arbiter_if.master  mem,
    output logic [1:0]        grant_o
);
    localparam int BYTES_PER_BEAT = TL_DW / 8;

    arb_state_e            state_q, state_d;
    logic                  lock_q, lock_d;
    logic                  hold_q, hold_idx_q;
    logic                  win_idx, sel_idx;
    logic                  hs, load, dec, last, d_idx;
    logic [3:0]            starve_cnt;
    logic [BEAT_CNT_W-1:0] beats;

    // A stalled winner keeps the grant; otherwise requester 0 wins unless requester 1 is starved.
    always_comb begin
        win_idx = req.a_valid[1] & (~req.a_valid[0] | (starve_cnt == 4'(STARVE_LIMIT)));
        if (hold_q && req.a_valid[hold_idx_q]) begin
            win_idx = hold_idx_q;
        end
        sel_idx = (state_q == BURST) ? lock_q : win_idx;
        grant_o = 2'b00;
        if (!rst) begin
            if (state_q == BURST) begin
                grant_o = lock_q ? 2'b10 : 2'b01;
            end else if (|req.a_valid) begin
                grant_o = win_idx ? 2'b10 : 2'b01;
            end
        end
    end

    assign mem.a_valid[0]   = |(grant_o & req.a_valid);
    assign req.a_ready      = grant_o & {2{mem.a_ready[0]}};
    assign hs               = mem.a_valid[0] & mem.a_ready[0];
    assign mem.a_opcode[0]  = req.a_opcode[sel_idx];
    assign mem.a_param[0]   = req.a_param[sel_idx];
    assign mem.a_size[0]    = req.a_size[sel_idx];
    assign mem.a_source[0]  = {sel_idx, req.a_source[sel_idx]};
    assign mem.a_address[0] = TL_AW'(req.a_address[sel_idx]);
    assign mem.a_mask[0]    = req.a_mask[sel_idx];
    assign mem.a_data[0]    = TL_DW'(req.a_data[sel_idx]);
    assign mem.a_corrupt[0] = req.a_corrupt[sel_idx];
    assign beats            = beat_count(req.a_opcode[sel_idx], req.a_size[sel_idx], BYTES_PER_BEAT);

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        load    = 1'b0;
        dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs && beats > BEAT_CNT_W'(1)) begin
                    state_d = BURST;
                    lock_d  = sel_idx;
                    load    = 1'b1;
                end
            end
            BURST: begin
                if (hs) begin
                    dec = 1'b1;
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    tl_beat_counter #(.W(BEAT_CNT_W)) u_beat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (beats - 1'b1),
        .dec      (dec),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_q     <= 1'b0;
            hold_q     <= 1'b0;
            hold_idx_q <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            hold_q     <= (state_q == IDLE) && mem.a_valid[0] && !mem.a_ready[0];
            hold_idx_q <= sel_idx;
            if (hs && grant_o[1]) begin
                starve_cnt <= 4'd0;
            end else if (req.a_valid[1] && !grant_o[1] && starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // D responses are steered purely by the index bit that was prepended to the source on A.
    always_comb begin
        d_idx = mem.d_source[0][TL_SW];
        for (int i = 0; i < 2; i++) begin
            req.d_opcode[i]  = mem.d_opcode[0];
            req.d_param[i]   = mem.d_param[0];
            req.d_size[i]    = mem.d_size[0];
            req.d_source[i]  = mem.d_source[0][TL_SW-1:0];
            req.d_denied[i]  = mem.d_denied[0];
            req.d_corrupt[i] = mem.d_corrupt[0];
            req.d_data[i]    = mem.d_data[0];
            req.d_valid[i]   = mem.d_valid[0] && (d_idx == 1'(i));
        end
        mem.d_ready[0] = req.d_ready[d_idx];
    end

endmodule

// File: tb/tb_tl_qos_arbiter.sv
// Self-checking bench for tl_qos_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_tl_qos_arbiter;
    import tl_qos_arbiter_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int SW    = 1;
    localparam int LIMIT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant_o;
    int         checks = 0;
    int         errors = 0;

    bit m_burst, m_held;
    int m_lock, m_left, m_wait, m_held_idx;

    always #5 clk = ~clk;

    tl_qos_arbiter_if #(.N(2), .DW(DW), .AW(AW), .SW(SW))     req_bus ();
    tl_qos_arbiter_if #(.N(1), .DW(DW), .AW(AW), .SW(SW + 1)) mem_bus ();

    tl_qos_arbiter #(.TL_DW(DW), .TL_AW(AW), .TL_SW(SW), .STARVE_LIMIT(LIMIT)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req_bus),
        .mem     (mem_bus),
        .grant_o (grant_o)
    );

    task automatic apply_stimulus(input int idx, input logic v, input logic [2:0] op,
                                  input logic [2:0] sz, input logic [AW-1:0] addr);
        req_bus.a_valid[idx]   = v;
        req_bus.a_opcode[idx]  = op;
        req_bus.a_param[idx]   = 3'd0;
        req_bus.a_size[idx]    = sz;
        req_bus.a_source[idx]  = addr[2];
        req_bus.a_address[idx] = addr;
        req_bus.a_mask[idx]    = '1;
        req_bus.a_data[idx]    = ~addr;
        req_bus.a_corrupt[idx] = 1'b0;
    endtask

    task automatic do_reset;
        apply_stimulus(0, 1'b0, GET, 3'd0, '0);
        apply_stimulus(1, 1'b0, GET, 3'd0, '0);
        mem_bus.a_ready     = 1'b1;
        mem_bus.d_valid     = 1'b0;
        mem_bus.d_opcode[0] = ACCESS_ACK;
        mem_bus.d_param[0]  = 2'd0;
        mem_bus.d_size[0]   = 3'd2;
        mem_bus.d_source[0] = 2'b00;
        mem_bus.d_denied    = 1'b0;
        mem_bus.d_corrupt   = 1'b0;
        mem_bus.d_data[0]   = '0;
        req_bus.d_ready     = 2'b11;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int model_beats(input int op, input int sz);
        int b;
        if (op == 0 || op == 1) begin
            b = (1 << sz) / (DW / 8);
            return (b < 1) ? 1 : b;
        end
        return 1;
    endfunction

    function automatic int model_owner(input logic [1:0] v);
        if (m_burst) return m_lock;
        if (m_held && v[m_held_idx]) return m_held_idx;
        if (v == 2'b00) return -1;
        if (v[1] && (!v[0] || m_wait == LIMIT)) return 1;
        return 0;
    endfunction

    task automatic test_reset;
        do_reset;
        rst = 1'b1;
        apply_stimulus(0, 1'b1, GET, 3'd2, 32'h100);
        apply_stimulus(1, 1'b1, GET, 3'd2, 32'h200);
        #1;
        checks++;
        if (grant_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 00", grant_o); end
        checks++;
        if (mem_bus.a_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_a_valid: got %b expected 0", mem_bus.a_valid[0]); end
        checks++;
        if (req_bus.a_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_a_ready: got %b expected 00", req_bus.a_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (grant_o !== 2'b01) begin errors++; $display("[TB] FAIL post_reset_grant: got %b expected 01", grant_o); end
        apply_stimulus(0, 1'b0, GET, 3'd0, '0);
        apply_stimulus(1, 1'b0, GET, 3'd0, '0);
        @(negedge clk);
    endtask

    task automatic test_starvation;
        logic [1:0] exp_grant;
        do_reset;
        apply_stimulus(0, 1'b1, GET, 3'd2, 32'h1000);
        apply_stimulus(1, 1'b1, GET, 3'd2, 32'h2004);
        for (int c = 1; c <= 10; c++) begin
            exp_grant = (c == 9) ? 2'b10 : 2'b01;
            #1;
            checks++;
            if (grant_o !== exp_grant) begin errors++; $display("[TB] FAIL starve_grant_c%0d: got %b expected %b", c, grant_o, exp_grant); end
            checks++;
            if (req_bus.a_ready !== exp_grant) begin errors++; $display("[TB] FAIL starve_ready_c%0d: got %b expected %b", c, req_bus.a_ready, exp_grant); end
            checks++;
            if (mem_bus.a_source[0] !== ((c == 9) ? 2'b11 : 2'b00)) begin
                errors++; $display("[TB] FAIL starve_source_c%0d: got %b", c, mem_bus.a_source[0]);
            end
            @(negedge clk);
        end
        apply_stimulus(0, 1'b0, GET, 3'd0, '0);
        apply_stimulus(1, 1'b0, GET, 3'd0, '0);
    endtask

    task automatic test_burst;
        do_reset;
        apply_stimulus(1, 1'b1, PUT_FULL_DATA, 3'd4, 32'h3000);
        #1;
        checks++;
        if (grant_o !== 2'b10) begin errors++; $display("[TB] FAIL burst_beat1_grant: got %b expected 10", grant_o); end
        @(negedge clk);
        apply_stimulus(0, 1'b1, GET, 3'd2, 32'h4000);
        for (int b = 2; b <= 4; b++) begin
            #1;
            checks++;
            if (grant_o !== 2'b10) begin errors++; $display("[TB] FAIL burst_beat%0d_grant: got %b expected 10", b, grant_o); end
            checks++;
            if (req_bus.a_ready !== 2'b10) begin errors++; $display("[TB] FAIL burst_beat%0d_ready: got %b expected 10", b, req_bus.a_ready); end
            checks++;
            if (mem_bus.a_address[0] !== 32'h3000) begin errors++; $display("[TB] FAIL burst_beat%0d_addr: got %h expected 3000", b, mem_bus.a_address[0]); end
            @(negedge clk);
        end
        apply_stimulus(1, 1'b0, GET, 3'd0, '0);
        #1;
        checks++;
        if (grant_o !== 2'b01) begin errors++; $display("[TB] FAIL burst_after_grant: got %b expected 01", grant_o); end
        @(negedge clk);
        apply_stimulus(0, 1'b0, GET, 3'd0, '0);
    endtask

    task automatic test_backpressure;
        do_reset;
        mem_bus.a_ready = 1'b0;
        apply_stimulus(0, 1'b1, GET, 3'd2, 32'h5008);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (grant_o !== 2'b01) begin errors++; $display("[TB] FAIL bp_grant_c%0d: got %b expected 01", c, grant_o); end
            checks++;
            if (mem_bus.a_address[0] !== 32'h5008 || mem_bus.a_valid[0] !== 1'b1) begin
                errors++; $display("[TB] FAIL bp_fields_c%0d: got addr %h valid %b expected 5008 1", c, mem_bus.a_address[0], mem_bus.a_valid[0]);
            end
            checks++;
            if (req_bus.a_ready !== 2'b00) begin errors++; $display("[TB] FAIL bp_ready_c%0d: got %b expected 00", c, req_bus.a_ready); end
            @(negedge clk);
            apply_stimulus(1, 1'b1, GET, 3'd2, 32'h6000);
        end
        mem_bus.a_ready = 1'b1;
        #1;
        checks++;
        if (req_bus.a_ready !== 2'b01) begin errors++; $display("[TB] FAIL bp_release_ready: got %b expected 01", req_bus.a_ready); end
        @(negedge clk);
        apply_stimulus(0, 1'b0, GET, 3'd0, '0);
        #1;
        checks++;
        if (grant_o !== 2'b10) begin errors++; $display("[TB] FAIL bp_next_grant: got %b expected 10", grant_o); end
        @(negedge clk);
        apply_stimulus(1, 1'b0, GET, 3'd0, '0);
    endtask

    task automatic test_d_channel;
        int   beat = 0;
        int   cyc  = 0;
        logic tog  = 1'b0;
        do_reset;
        mem_bus.d_valid     = 1'b1;
        mem_bus.d_source[0] = 2'b10;
        mem_bus.d_opcode[0] = ACCESS_ACK_DATA;
        mem_bus.d_size[0]   = 3'd4;
        while (beat < 4 && cyc < 20) begin
            mem_bus.d_data[0] = 32'hD000_0000 + 32'(beat);
            req_bus.d_ready   = {tog, ~tog};
            #1;
            checks++;
            if (req_bus.d_valid !== 2'b10) begin errors++; $display("[TB] FAIL d_valid_c%0d: got %b expected 10", cyc, req_bus.d_valid); end
            checks++;
            if (req_bus.d_source[1] !== 1'b0 || req_bus.d_opcode[1] !== 3'd1) begin
                errors++; $display("[TB] FAIL d_fields_c%0d: got src %b op %0d expected 0 1", cyc, req_bus.d_source[1], req_bus.d_opcode[1]);
            end
            checks++;
            if (req_bus.d_data[1] !== 32'hD000_0000 + 32'(beat)) begin
                errors++; $display("[TB] FAIL d_data_c%0d: got %h expected %h", cyc, req_bus.d_data[1], 32'hD000_0000 + 32'(beat));
            end
            checks++;
            if (mem_bus.d_ready[0] !== tog) begin errors++; $display("[TB] FAIL d_ready_c%0d: got %b expected %b", cyc, mem_bus.d_ready[0], tog); end
            @(posedge clk);
            if (tog) beat++;
            tog = ~tog;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (beat != 4) begin errors++; $display("[TB] FAIL d_beats_timeout: got %0d beats expected 4", beat); end
        mem_bus.d_valid = 1'b0;
        req_bus.d_ready = 2'b11;
    endtask

    task automatic test_reset_mid_burst;
        do_reset;
        apply_stimulus(0, 1'b1, PUT_FULL_DATA, 3'd4, 32'h7000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (grant_o !== 2'b00 || mem_bus.a_valid[0] !== 1'b0 || req_bus.a_ready !== 2'b00) begin
            errors++; $display("[TB] FAIL midburst_reset: got grant %b valid %b ready %b expected 00 0 00", grant_o, mem_bus.a_valid[0], req_bus.a_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(0, 1'b0, GET, 3'd0, '0);
        apply_stimulus(1, 1'b1, GET, 3'd2, 32'h8004);
        #1;
        checks++;
        if (grant_o !== 2'b10 || mem_bus.a_valid[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL midburst_idle_after: got grant %b valid %b expected 10 1", grant_o, mem_bus.a_valid[0]);
        end
        @(negedge clk);
        apply_stimulus(1, 1'b0, GET, 3'd0, '0);
        apply_stimulus(0, 1'b1, GET, 3'd2, 32'h9000);
        #1;
        checks++;
        if (grant_o !== 2'b01) begin errors++; $display("[TB] FAIL midburst_next_grant: got %b expected 01", grant_o); end
        @(negedge clk);
        apply_stimulus(0, 1'b0, GET, 3'd0, '0);
    endtask

    task automatic test_random;
        logic [1:0]    v, exp_grant, ds, dr;
        logic [2:0]    op [2];
        logic [2:0]    sz [2];
        logic [AW-1:0] addr [2];
        logic          rdy, exp_valid, hs, dv;
        bit            was_burst;
        int            owner, k, nb;
        do_reset;
        m_burst = 0; m_held = 0; m_lock = 0; m_left = 0; m_wait = 0; m_held_idx = 0;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                v[r]    = ($urandom_range(0, 3) != 0);
                k       = $urandom_range(0, 2);
                op[r]   = (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : 3'd4;
                sz[r]   = 3'($urandom_range(0, 4));
                addr[r] = $urandom;
                apply_stimulus(r, v[r], op[r], sz[r], addr[r]);
            end
            rdy = ($urandom_range(0, 3) != 0);
            mem_bus.a_ready = rdy;
            dv = 1'($urandom_range(0, 1));
            ds = 2'($urandom_range(0, 3));
            dr = 2'($urandom_range(0, 3));
            mem_bus.d_valid     = dv;
            mem_bus.d_source[0] = ds;
            req_bus.d_ready     = dr;
            #1;
            owner     = model_owner(v);
            exp_grant = (owner == 1) ? 2'b10 : (owner == 0) ? 2'b01 : 2'b00;
            exp_valid = (owner == 1) ? v[1] : (owner == 0) ? v[0] : 1'b0;
            checks++;
            if (grant_o !== exp_grant) begin errors++; $display("[TB] FAIL rand_grant_c%0d: got %b expected %b", c, grant_o, exp_grant); end
            checks++;
            if (mem_bus.a_valid[0] !== exp_valid) begin errors++; $display("[TB] FAIL rand_valid_c%0d: got %b expected %b", c, mem_bus.a_valid[0], exp_valid); end
            checks++;
            if (req_bus.a_ready !== (exp_grant & {2{rdy}})) begin
                errors++; $display("[TB] FAIL rand_ready_c%0d: got %b expected %b", c, req_bus.a_ready, exp_grant & {2{rdy}});
            end
            if (exp_valid) begin
                checks++;
                if (mem_bus.a_source[0] !== {owner == 1, addr[owner][2]} || mem_bus.a_address[0] !== addr[owner]) begin
                    errors++; $display("[TB] FAIL rand_fields_c%0d: got src %b addr %h expected %b %h", c, mem_bus.a_source[0], mem_bus.a_address[0], {owner == 1, addr[owner][2]}, addr[owner]);
                end
            end
            checks++;
            if (req_bus.d_valid !== (dv ? (ds[1] ? 2'b10 : 2'b01) : 2'b00) || mem_bus.d_ready[0] !== dr[ds[1]]) begin
                errors++; $display("[TB] FAIL rand_d_c%0d: got valid %b ready %b", c, req_bus.d_valid, mem_bus.d_ready[0]);
            end
            @(posedge clk);
            hs = exp_valid && rdy;
            was_burst = m_burst;
            if (!was_burst) begin
                if (hs) begin
                    nb = model_beats(int'(op[owner]), int'(sz[owner]));
                    if (nb > 1) begin
                        m_burst = 1; m_lock = owner; m_left = nb - 1;
                    end
                end
            end else if (hs) begin
                m_left--;
                if (m_left == 0) m_burst = 0;
            end
            m_held = !was_burst && exp_valid && !rdy;
            if (m_held) m_held_idx = owner;
            if (hs && owner == 1) m_wait = 0;
            else if (v[1] && owner != 1 && m_wait < 15) m_wait++;
            @(negedge clk);
        end
        apply_stimulus(0, 1'b0, GET, 3'd0, '0);
        apply_stimulus(1, 1'b0, GET, 3'd0, '0);
        mem_bus.d_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset;
        test_starvation;
        test_burst;
        test_backpressure;
        test_d_channel;
        test_reset_mid_burst;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
